clk_monitor: RTL
================

Name: clk_monitor

Overview:
- Synthesizable measurement stage downstream of the configurable clock generator.
- Samples the generator's reference clock and phase-shifted clock in the system clock domain.
- Measures high time, low time, period and ref-to-phase delay in system clock cycles.
- Flags a stuck (stopped) input clock; results feed the self-check / status path.

Parameters:
CNT_W, 16, width of the high/low/phase counters and their result registers
SYNC_STAGES, 2, synchronizer flops per async input (legal values 2..4)
TIMEOUT_CYC, 65535, cycles without an expected edge before stuck is flagged; must be < 2^CNT_W

Ports:
clk  input  1  system sampling clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  measurement enable, synchronous to clk
clk_in_ref  input  1  reference clock under test, asynchronous
clk_in_phase  input  1  phase-shifted clock under test, asynchronous
high_time  output  CNT_W  last measured high time, in clk cycles
low_time  output  CNT_W  last measured low time, in clk cycles
period  output  CNT_W+1  last measured period, high_time+low_time
phase_time  output  CNT_W  ref-rise to phase-rise delay (PHASE_MEAS_EN only)
meas_valid  output  1  one-cycle pulse when the result registers update
stuck  output  1  input clock stopped; sticky until next good measurement
stuck_level  output  1  synchronized level of clk_in_ref when stuck was set

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0; synchronizer flops 0.
- Sync: SYNC_STAGES flops per input, plus one history flop. Rise is detected when sync=1 and hist=0; fall when sync=0 and hist=1. Detection latency is SYNC_STAGES+1 cycles, identical for both inputs, so relative timing is preserved.
- FSM states: IDLE, ARM, HIGH, LOW.
  - IDLE: en=1 -> ARM.
  - ARM: waits for rise. On rise -> HIGH with hi_cnt=1. The first partial cycle is never reported.
  - HIGH: hi_cnt+1 each cycle. On fall -> LOW with lo_cnt=1.
  - LOW: lo_cnt+1 each cycle. On rise: latch high_time=hi_cnt, low_time=lo_cnt, period=hi_cnt+lo_cnt (zero-extended add, no overflow). Then go to HIGH with hi_cnt=1 (continuous measurement).
- Result timing: meas_valid pulses the cycle after the latch. The result registers are stable on that cycle. A successful latch clears stuck.
- Counters saturate at 2^CNT_W-1.
- Timeout: in ARM, HIGH or LOW, if the active counter (idle counter in ARM) reaches TIMEOUT_CYC:
  - set stuck=1 and stuck_level=current sync level of clk_in_ref;
  - go to ARM and clear counters;
  - result registers hold their values; no meas_valid.
- en=0 in any state: next cycle IDLE, counters cleared, no meas_valid. Results and stuck hold their values.
- en re-asserted: restart from ARM.
- Simultaneous timeout and edge: the edge wins.
- rst asserted mid-measurement: immediate return to reset values.

Optional Feature:
- Macro: CLK_MONITOR_PHASE_MEAS_EN.
- Defined:
  - ph_cnt clears to 0 on each ref rise and increments each cycle.
  - A phase rise latches phase_time=ph_cnt at the next meas_valid; only the first phase rise per ref period counts.
  - A phase rise in the same cycle as a ref rise gives 0.
  - No phase rise within the period: phase_time=period[CNT_W-1:0].
- Undefined: no phase synchronizer, no ph_cnt; phase_time tied to 0. clk_in_phase is unused.

Test Plan:
- clk 10 ns. Ref period 200 ns, 30% duty, edges offset 3 ns from clk rise, en=1 -> after first full period, high_time=6, low_time=14, period=20, meas_valid pulses once per 200 ns.
- Same ref, phase clock delayed 50 ns (90 deg), macro defined -> phase_time=5 on every meas_valid. With the macro undefined -> phase_time=0.
- Ref held at 1 after lock, TIMEOUT_CYC=100 -> stuck=1 and stuck_level=1 about 100 cycles after the last rise. Results hold 6/14/20. Restarting the clock -> stuck=0 on the next meas_valid.
- Deassert en during HIGH, re-assert 300 ns later -> no meas_valid while disabled. The first new meas_valid comes only after a complete rise-fall-rise sequence; values remain 6/14/20.
- Assert rst mid-LOW -> all outputs 0 immediately. With en=1 after release, the first meas_valid comes no earlier than one full ref period plus SYNC_STAGES+2 cycles.
- 50% duty ref, period 20 ns (2 clk cycles) -> high_time=1, low_time=1, period=2, meas_valid every 2 cycles.

Source files
------------

// File: rtl/clk_monitor.sv
// Clock monitor: measures high/low time and period of an asynchronous reference clock in clk cycles,
// and flags a stopped clock. Define CLK_MONITOR_PHASE_MEAS_EN to also measure the ref-to-phase delay.
module clk_monitor #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clk_in_ref,
   input  logic             clk_in_phase,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W-1:0] low_time,
   output logic [CNT_W:0]   period,
   output logic [CNT_W-1:0] phase_time,
   output logic             meas_valid,
   output logic             stuck,
   output logic             stuck_level
);

   typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYC);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // Reference synchronizer plus history flop for edge detection.
   logic [SYNC_STAGES-1:0] ref_sync_q;
   logic                   ref_hist_q;
   logic                   ref_lvl, ref_rise, ref_fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_sync_q <= '0;
         ref_hist_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain shifts by one.
         ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], clk_in_ref};
         ref_hist_q <= ref_sync_q[SYNC_STAGES-1];
      end
   end

   assign ref_lvl  = ref_sync_q[SYNC_STAGES-1];
   assign ref_rise = ref_lvl & ~ref_hist_q;
   assign ref_fall = ~ref_lvl & ref_hist_q;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
   logic [CNT_W-1:0] arm_cnt_q, arm_cnt_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] low_q, low_d;
   logic [CNT_W:0]   period_q, period_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic             meas_valid_q, meas_valid_d;
   logic             stuck_q, stuck_d;
   logic             stuck_level_q, stuck_level_d;
   logic             timeout, latch;
   logic [CNT_W:0]   period_sum;
   logic [CNT_W-1:0] phase_meas;

   assign period_sum = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};

`ifdef CLK_MONITOR_PHASE_MEAS_EN
   logic [SYNC_STAGES-1:0] ph_sync_q;
   logic                   ph_hist_q;
   logic                   ph_rise;
   logic [CNT_W-1:0]       ph_cnt_q, ph_cnt_d;
   logic [CNT_W-1:0]       ph_cap_q, ph_cap_d;
   logic [CNT_W-1:0]       ph_now;
   logic                   ph_seen_q, ph_seen_d;

   assign ph_rise = ph_sync_q[SYNC_STAGES-1] & ~ph_hist_q;
   assign ph_now  = ref_rise ? '0 : ph_cnt_q;

   always_comb begin
      ph_cnt_d  = ref_rise ? CNT_ONE : sat_inc(ph_cnt_q);
      ph_cap_d  = ph_cap_q;
      ph_seen_d = ph_seen_q & ~ref_rise;
      // A phase rise coincident with a ref rise opens the new period with a delay of 0.
      if (ph_rise && !ph_seen_d) begin
         ph_cap_d  = ph_now;
         ph_seen_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph_sync_q <= '0;
         ph_hist_q <= 1'b0;
         ph_cnt_q  <= '0;
         ph_cap_q  <= '0;
         ph_seen_q <= 1'b0;
      end else begin
         ph_sync_q <= {ph_sync_q[SYNC_STAGES-2:0], clk_in_phase};
         ph_hist_q <= ph_sync_q[SYNC_STAGES-1];
         ph_cnt_q  <= ph_cnt_d;
         ph_cap_q  <= ph_cap_d;
         ph_seen_q <= ph_seen_d;
      end
   end

   // ph_seen_q still describes the period that the current ref rise closes.
   assign phase_meas = ph_seen_q ? ph_cap_q : period_sum[CNT_W-1:0];
`else
   logic phase_unused;
   assign phase_unused = clk_in_phase;
   assign phase_meas   = '0;
`endif

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
      state_d       = state_q;
      hi_cnt_d      = hi_cnt_q;
      lo_cnt_d      = lo_cnt_q;
      arm_cnt_d     = arm_cnt_q;
      high_d        = high_q;
      low_d         = low_q;
      period_d      = period_q;
      phase_d       = phase_q;
      meas_valid_d  = 1'b0;
      stuck_d       = stuck_q;
      stuck_level_d = stuck_level_q;
      timeout       = 1'b0;
      latch         = 1'b0;

      if (!en) begin
         state_d   = IDLE;
         hi_cnt_d  = '0;
         lo_cnt_d  = '0;
         arm_cnt_d = '0;
      end else begin
         // Edges are tested before the timeout so a coincident edge always wins.
         unique case (state_q)
            IDLE: state_d = ARM;
            ARM: begin
               if (ref_rise) begin
                  state_d   = HIGH;
                  hi_cnt_d  = CNT_ONE;
                  arm_cnt_d = '0;
               end else if (arm_cnt_q >= TIMEOUT) begin
                  timeout = 1'b1;
               end else begin
                  arm_cnt_d = sat_inc(arm_cnt_q);
               end
            end
            HIGH: begin
               if (ref_fall) begin
                  state_d  = LOW;
                  lo_cnt_d = CNT_ONE;
               end else if (hi_cnt_q >= TIMEOUT) begin
                  timeout = 1'b1;
               end else begin
                  hi_cnt_d = sat_inc(hi_cnt_q);
               end
            end
            LOW: begin
               if (ref_rise) begin
                  latch    = 1'b1;
                  state_d  = HIGH;
                  hi_cnt_d = CNT_ONE;
                  lo_cnt_d = '0;
               end else if (lo_cnt_q >= TIMEOUT) begin
                  timeout = 1'b1;
               end else begin
                  lo_cnt_d = sat_inc(lo_cnt_q);
               end
            end
            default: state_d = IDLE;
         endcase

         if (timeout) begin
            state_d       = ARM;
            hi_cnt_d      = '0;
            lo_cnt_d      = '0;
            arm_cnt_d     = '0;
            stuck_d       = 1'b1;
            stuck_level_d = ref_lvl;
         end

         if (latch) begin
            high_d       = hi_cnt_q;
            low_d        = lo_cnt_q;
            period_d     = period_sum;
            phase_d      = phase_meas;
            meas_valid_d = 1'b1;
            stuck_d      = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         hi_cnt_q      <= '0;
         lo_cnt_q      <= '0;
         arm_cnt_q     <= '0;
         high_q        <= '0;
         low_q         <= '0;
         period_q      <= '0;
         phase_q       <= '0;
         meas_valid_q  <= 1'b0;
         stuck_q       <= 1'b0;
         stuck_level_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hi_cnt_q      <= hi_cnt_d;
         lo_cnt_q      <= lo_cnt_d;
         arm_cnt_q     <= arm_cnt_d;
         high_q        <= high_d;
         low_q         <= low_d;
         period_q      <= period_d;
         phase_q       <= phase_d;
         meas_valid_q  <= meas_valid_d;
         stuck_q       <= stuck_d;
         stuck_level_q <= stuck_level_d;
      end
   end

   assign high_time   = high_q;
   assign low_time    = low_q;
   assign period      = period_q;
   assign phase_time  = phase_q;
   assign meas_valid  = meas_valid_q;
   assign stuck       = stuck_q;
   assign stuck_level = stuck_level_q;

endmodule
